// File: rtl/state_tower_checker_pkg.sv
// Shared types and the reference tower model for the state-tower checker.
package state_tower_checker_pkg;

    localparam int unsigned TS_W   = 2;
    localparam int unsigned NUM_TS = 4;

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        RESYNC = 2'd1,
        FAULT  = 2'd2
    } fsm_e;

    typedef logic [TS_W-1:0] tstate_t;

    localparam tstate_t TS_RESET = 2'b11;

    // Tower output for state s={st0,st1} given the input bit.
    function automatic logic tower_out(input tstate_t s, input logic in_b);
        return in_b ? s[1] : s[0];
    endfunction

    // Tower next state for state s given the input bit.
    function automatic tstate_t tower_next(input tstate_t s, input logic in_b);
        return in_b ? s : {s[0], s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/state_tower_cand_step.sv
// Advances a candidate-state mask by one observed (in, out) tower step.
module state_tower_cand_step
    import state_tower_checker_pkg::*;
(
    input  logic [NUM_TS-1:0] cand_i,
    input  logic              obs_in_i,
    input  logic              obs_out_i,
    output logic [NUM_TS-1:0] cand_nxt_c_o
);

    tstate_t s_b;

    always_comb begin
        cand_nxt_c_o = '0;
        s_b          = '0;
        for (int unsigned s = 0; s < NUM_TS; s++) begin
            s_b = tstate_t'(s);
            if (cand_i[s_b] && (tower_out(s_b, obs_in_i) == obs_out_i)) begin
                cand_nxt_c_o[tower_next(s_b, obs_in_i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/state_tower_checker.sv
// Tracks an observed state tower, flags mismatches and re-synchronises by
// narrowing a candidate set; unrecoverable divergence parks in FAULT until clr.
module state_tower_checker
    import state_tower_checker_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             obs_valid_i,
    input  logic             obs_in_i,
    input  logic             obs_out_i,
    input  logic             clr_i,
    output logic             synced_o,
    output logic [TS_W-1:0]  state_est_o,
    output logic             err_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] obs_cnt_o,
    output logic [CNT_W-1:0] mism_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm_e              state_q;
    tstate_t           est_q;
    logic [NUM_TS-1:0] cand_q;
    logic              err_q;
    logic              synced_q;
    logic              fault_q;
    logic [CNT_W-1:0]  obs_cnt_q;
    logic [CNT_W-1:0]  mism_cnt_q;

    logic [NUM_TS-1:0] cand_src;
    logic [NUM_TS-1:0] cand_nxt;
    logic              track_hit;
    logic              surv_one;
    logic              surv_none;
    tstate_t           surv_idx;
    logic [CNT_W-1:0]  obs_cnt_inc;
    logic [CNT_W-1:0]  mism_cnt_inc;

    // A TRACK mismatch restarts the search from every possible state.
    assign cand_src = (state_q == TRACK) ? '1 : cand_q;

    state_tower_cand_step u_cand_step (
        .cand_i       (cand_src),
        .obs_in_i     (obs_in_i),
        .obs_out_i    (obs_out_i),
        .cand_nxt_c_o (cand_nxt)
    );

    assign track_hit    = (tower_out(est_q, obs_in_i) == obs_out_i);
    assign surv_one     = $onehot(cand_nxt);
    assign surv_none    = (cand_nxt == '0);
    assign obs_cnt_inc  = (obs_cnt_q  == CNT_MAX) ? obs_cnt_q  : obs_cnt_q  + CNT_W'(1);
    assign mism_cnt_inc = (mism_cnt_q == CNT_MAX) ? mism_cnt_q : mism_cnt_q + CNT_W'(1);

    always_comb begin
        surv_idx = '0;
        for (int unsigned s = 0; s < NUM_TS; s++) begin
            if (cand_nxt[s]) surv_idx = tstate_t'(s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TRACK;
            est_q      <= TS_RESET;
            cand_q     <= '0;
            err_q      <= 1'b0;
            synced_q   <= 1'b1;
            fault_q    <= 1'b0;
            obs_cnt_q  <= '0;
            mism_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (clr_i) begin
                state_q    <= TRACK;
                est_q      <= TS_RESET;
                cand_q     <= '0;
                synced_q   <= 1'b1;
                fault_q    <= 1'b0;
                obs_cnt_q  <= '0;
                mism_cnt_q <= '0;
            end else if (obs_valid_i) begin
                obs_cnt_q <= obs_cnt_inc;
                case (state_q)
                    TRACK: begin
                        if (track_hit) begin
                            est_q <= tower_next(est_q, obs_in_i);
                        end else begin
                            err_q      <= 1'b1;
                            mism_cnt_q <= mism_cnt_inc;
                            cand_q     <= cand_nxt;
                            state_q    <= RESYNC;
                            synced_q   <= 1'b0;
                        end
                    end
                    RESYNC: begin
                        cand_q <= cand_nxt;
                        if (surv_one) begin
                            state_q  <= TRACK;
                            synced_q <= 1'b1;
                            est_q    <= surv_idx;
                        end else if (surv_none) begin
                            state_q    <= FAULT;
                            fault_q    <= 1'b1;
                            err_q      <= 1'b1;
                            mism_cnt_q <= mism_cnt_inc;
                        end
                    end
                    FAULT: begin
                    end
                    default: begin
                        state_q  <= FAULT;
                        synced_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign synced_o    = synced_q;
    assign state_est_o = est_q;
    assign err_o       = err_q;
    assign fault_o     = fault_q;
    assign obs_cnt_o   = obs_cnt_q;
    assign mism_cnt_o  = mism_cnt_q;

endmodule

// File: tb/tb_state_tower_checker.sv
// Randomised self-checking bench: two checker instances (8-bit and 2-bit
// counters) compared every cycle against a set-based behavioural model.
module tb_state_tower_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic obs_valid = 1'b0;
    logic obs_in = 1'b0;
    logic obs_out = 1'b0;
    logic clr = 1'b0;

    logic       a_synced, a_err, a_fault;
    logic [1:0] a_est;
    logic [7:0] a_obs, a_mism;
    logic       b_synced, b_err, b_fault;
    logic [1:0] b_est;
    logic [1:0] b_obs, b_mism;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    // Behavioural model: mode 0 tracking, 1 searching, 2 faulted.
    int m_mode, m_est;
    int m_cands[$];
    bit m_err;
    int m_obs8, m_mism8, m_obs2, m_mism2;

    always #5 clk = ~clk;

    state_tower_checker #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .obs_valid_i(obs_valid), .obs_in_i(obs_in),
        .obs_out_i(obs_out), .clr_i(clr), .synced_o(a_synced), .state_est_o(a_est),
        .err_o(a_err), .fault_o(a_fault), .obs_cnt_o(a_obs), .mism_cnt_o(a_mism)
    );

    state_tower_checker #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .obs_valid_i(obs_valid), .obs_in_i(obs_in),
        .obs_out_i(obs_out), .clr_i(clr), .synced_o(b_synced), .state_est_o(b_est),
        .err_o(b_err), .fault_o(b_fault), .obs_cnt_o(b_obs), .mism_cnt_o(b_mism)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // st0 is the high digit, st1 the low digit of s in 0..3.
    function automatic int m_out(input int s, input int i);
        return (i != 0) ? s / 2 : s % 2;
    endfunction

    function automatic int m_next(input int s, input int i);
        return (i != 0) ? s : (s % 2) * 2 + ((s / 2) ^ (s % 2));
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_est = 3; m_cands = {}; m_err = 0;
        m_obs8 = 0; m_mism8 = 0; m_obs2 = 0; m_mism2 = 0;
    endtask

    task automatic model_step(input bit v, input bit i, input bit o, input bit c);
        int nq[$];
        int n;
        m_err = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (!v) return;
        m_obs8 = sat(m_obs8, 255);
        m_obs2 = sat(m_obs2, 3);
        if (m_mode == 2) return;
        if (m_mode == 0) begin
            if (m_out(m_est, i) == int'(o)) begin
                m_est = m_next(m_est, i);
                return;
            end
            m_cands = {0, 1, 2, 3};
            m_err = 1;
            m_mism8 = sat(m_mism8, 255);
            m_mism2 = sat(m_mism2, 3);
        end
        nq = {};
        foreach (m_cands[k]) begin
            if (m_out(m_cands[k], i) == int'(o)) begin
                n = m_next(m_cands[k], i);
                if (!(n inside {nq})) nq.push_back(n);
            end
        end
        m_cands = nq;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (nq.size() == 1) begin
            m_mode = 0;
            m_est = nq[0];
        end else if (nq.size() == 0) begin
            m_mode = 2;
            m_err = 1;
            m_mism8 = sat(m_mism8, 255);
            m_mism2 = sat(m_mism2, 3);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":synced8"}, 32'(a_synced), 32'(m_mode == 0));
        chk({ph, ":fault8"},  32'(a_fault),  32'(m_mode == 2));
        chk({ph, ":err8"},    32'(a_err),    32'(m_err));
        chk({ph, ":obs8"},    32'(a_obs),    32'(m_obs8));
        chk({ph, ":mism8"},   32'(a_mism),   32'(m_mism8));
        chk({ph, ":synced2"}, 32'(b_synced), 32'(m_mode == 0));
        chk({ph, ":fault2"},  32'(b_fault),  32'(m_mode == 2));
        chk({ph, ":err2"},    32'(b_err),    32'(m_err));
        chk({ph, ":obs2"},    32'(b_obs),    32'(m_obs2));
        chk({ph, ":mism2"},   32'(b_mism),   32'(m_mism2));
        if (m_mode == 0) begin
            chk({ph, ":est8"}, 32'(a_est), 32'(m_est));
            chk({ph, ":est2"}, 32'(b_est), 32'(m_est));
        end
    endtask

    task automatic step(input bit v, input bit i, input bit o, input bit c, input string ph);
        @(negedge clk);
        obs_valid = v; obs_in = i; obs_out = o; clr = c;
        @(posedge clk);
        model_step(v, i, o, c);
        #1;
        check_all(ph);
    endtask

    // Reset is raised between edges so its asynchronous effect is visible at once.
    task automatic do_reset(input string ph);
        @(negedge clk);
        obs_valid = 1'b0; clr = 1'b0; rst = 1'b1;
        #2;
        model_reset();
        check_all({ph, ":async"});
        @(posedge clk);
        #1;
        check_all({ph, ":held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int tt;
        bit v, i, o, c;
        model_reset();

        do_reset("rst0");
        chk("rst0:est", 32'(a_est), 32'd3);

        step(1, 0, 1, 0, "trk1");
        chk("trk1:est", 32'(a_est), 32'd2);
        step(1, 0, 0, 0, "trk2");
        chk("trk2:est", 32'(a_est), 32'd1);
        step(1, 0, 1, 0, "trk3");
        chk("trk3:est", 32'(a_est), 32'd3);
        chk("trk3:obs", 32'(a_obs), 32'd3);

        do_reset("rst1");
        step(1, 1, 0, 0, "mis1");
        chk("mis1:err", 32'(a_err), 32'd1);
        chk("mis1:synced", 32'(a_synced), 32'd0);
        step(1, 0, 1, 0, "res1");
        chk("res1:synced", 32'(a_synced), 32'd1);
        chk("res1:est", 32'(a_est), 32'd3);

        do_reset("rst2");
        step(1, 1, 0, 0, "mis2");
        step(1, 1, 1, 0, "flt1");
        chk("flt1:fault", 32'(a_fault), 32'd1);
        chk("flt1:mism", 32'(a_mism), 32'd2);
        step(1, 0, 1, 0, "flt2");
        step(0, 1, 1, 0, "flt3");
        step(1, 1, 0, 0, "flt4");
        chk("flt4:obs", 32'(a_obs), 32'd4);
        step(1, 1, 0, 1, "clr1");
        chk("clr1:fault", 32'(a_fault), 32'd0);
        chk("clr1:obs", 32'(a_obs), 32'd0);
        chk("clr1:est", 32'(a_est), 32'd3);

        do_reset("rst3");
        for (int k = 0; k < 5; k++) step(1, 1, 1, 0, "sat");
        chk("sat:obs2", 32'(b_obs), 32'd3);
        chk("sat:obs8", 32'(a_obs), 32'd5);
        step(1, 1, 0, 0, "mis3");
        do_reset("rst4");
        chk("rst4:synced2", 32'(b_synced), 32'd1);
        chk("rst4:obs2", 32'(b_obs), 32'd0);

        tt = 3;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_rst");
                tt = 3;
                continue;
            end
            v = ($urandom_range(0, 3) != 0);
            i = 1'($urandom_range(0, 1));
            o = 1'(m_out(tt, int'(i))) ^ ($urandom_range(0, 11) == 0);
            c = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
            if (c) tt = 3;
            else if (v) tt = m_next(tt, int'(i));
            step(v, i, o, c, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
